// File: rtl/qpsk_modulator.sv
// qpsk_modulator
//   QPSK symbol mapper and rectangular upsampler for the TX baseband path.
//   One dibit (i_I, i_Q) is accepted per symbol and mapped to a signed
//   DATA_W-bit I/Q sample, which is held on the outputs for SPS clock cycles.
//   When the final sample of a symbol goes out and a new dibit is offered,
//   the new symbol follows with no gap cycle.
//
// Configuration macro:
//   QPSK_DIFF_EN  defined   -> differential (DQPSK) encoding through a 2-bit
//                              phase accumulator
//                 undefined -> absolute mapping, bit 0 -> +AMP, bit 1 -> -AMP
//
// Ports:
//   clk      in   1       system clock
//   rst_n    in   1       asynchronous active-low reset
//   i_I      in   1       in-phase bit of the offered symbol
//   i_Q      in   1       quadrature bit of the offered symbol
//   i_valid  in   1       symbol valid
//   o_ready  out  1       a symbol can be accepted this cycle (combinational)
//   o_valid  out  1       o_I/o_Q carry a valid sample
//   o_I      out  DATA_W  signed in-phase sample
//   o_Q      out  DATA_W  signed quadrature sample
//
// States:
//   state    | meaning
//   ST_IDLE  | no symbol being held past its first sample (always for SPS == 1)
//   ST_HOLD  | repeating the current symbol; cnt counts samples already shown

module qpsk_modulator #(
    parameter int DATA_W = 12,
    parameter int AMP    = 1448,
    parameter int SPS    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_I,
    input  logic                     i_Q,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic                     o_valid,
    output logic signed [DATA_W-1:0] o_I,
    output logic signed [DATA_W-1:0] o_Q
);

    // Keep the counter at least one bit wide so SPS == 1 still elaborates.
    localparam int                       CNT_W    = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(SPS - 1);
    localparam logic signed [DATA_W-1:0] POS_AMP  = DATA_W'(AMP);
    localparam logic signed [DATA_W-1:0] NEG_AMP  = -POS_AMP;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                     state, state_nxt;
    logic [CNT_W-1:0]           cnt, cnt_nxt;
    logic                       ready_en;
    logic                       valid_nxt;
    logic signed [DATA_W-1:0]   smp_i_nxt, smp_q_nxt;
    logic                       accept;
    logic                       sym_i, sym_q;

    assign o_ready = ready_en && ((state == ST_IDLE) || (cnt == CNT_LAST));
    assign accept  = i_valid && o_ready;

`ifdef QPSK_DIFF_EN
    logic [1:0] phase, phase_inc, phase_nxt;

    // Gray-ordered increment so adjacent phase steps differ by one bit.
    always_comb begin
        phase_inc = 2'd0;
        case ({i_I, i_Q})
            2'b00:   phase_inc = 2'd0;
            2'b01:   phase_inc = 2'd1;
            2'b11:   phase_inc = 2'd2;
            default: phase_inc = 2'd3;
        endcase
    end

    assign phase_nxt = phase + phase_inc;

    // The sample reflects the phase after this symbol's increment:
    // 0 -> (+,+), 1 -> (-,+), 2 -> (-,-), 3 -> (+,-).
    assign sym_i = phase_nxt[1] ^ phase_nxt[0];
    assign sym_q = phase_nxt[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 2'd0;
        end else if (accept) begin
            phase <= phase_nxt;
        end
    end
`else
    assign sym_i = i_I;
    assign sym_q = i_Q;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        valid_nxt = o_valid;
        smp_i_nxt = o_I;
        smp_q_nxt = o_Q;

        if (accept) begin
            valid_nxt = 1'b1;
            smp_i_nxt = sym_i ? NEG_AMP : POS_AMP;
            smp_q_nxt = sym_q ? NEG_AMP : POS_AMP;
            cnt_nxt   = '0;
            state_nxt = (SPS > 1) ? ST_HOLD : ST_IDLE;
        end else if ((state == ST_HOLD) && (cnt != CNT_LAST)) begin
            cnt_nxt   = cnt + CNT_W'(1);
        end else begin
            // Symbol finished (or nothing in flight) and no new dibit offered.
            valid_nxt = 1'b0;
            smp_i_nxt = '0;
            smp_q_nxt = '0;
            cnt_nxt   = '0;
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ready_en <= 1'b0;
            o_valid  <= 1'b0;
            o_I      <= '0;
            o_Q      <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ready_en <= 1'b1;
            o_valid  <= valid_nxt;
            o_I      <= smp_i_nxt;
            o_Q      <= smp_q_nxt;
        end
    end

endmodule

// File: tb/tb_qpsk_modulator.sv
// tb_qpsk_modulator
//   Two instances share clock and reset: one with SPS = 1 (streaming, gaps,
//   differential sequence) and one with SPS = 4 (hold, seamless reload,
//   ignored symbol, mid-symbol reset). Expected samples are produced by a
//   small reference mapper and queued per instance when a symbol is accepted.

module tb_qpsk_modulator;

    localparam logic signed [11:0] A = 12'sd1448;

    typedef struct {
        logic              v;
        logic signed [11:0] i;
        logic signed [11:0] q;
    } smp_t;

    logic clk = 1'b0;
    logic rst_n;

    logic               d1_v, d1_i, d1_q, rdy1, ov1;
    logic signed [11:0] oi1, oq1;
    logic               d4_v, d4_i, d4_q, rdy4, ov4;
    logic signed [11:0] oi4, oq4;

    int   total = 0;
    int   bad   = 0;
    smp_t sb1[$];
    smp_t sb4[$];
    logic [1:0] ph1 = 2'd0;
    logic [1:0] ph4 = 2'd0;

    always #5 clk = ~clk;

    qpsk_modulator #(.DATA_W(12), .AMP(1448), .SPS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_I(d1_i), .i_Q(d1_q), .i_valid(d1_v),
        .o_ready(rdy1), .o_valid(ov1), .o_I(oi1), .o_Q(oq1)
    );

    qpsk_modulator #(.DATA_W(12), .AMP(1448), .SPS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .i_I(d4_i), .i_Q(d4_q), .i_valid(d4_v),
        .o_ready(rdy4), .o_valid(ov4), .o_I(oi4), .o_Q(oq4)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input logic bi, input logic bq, input logic [1:0] p_in,
                         output logic [1:0] p_out,
                         output logic signed [11:0] ei, output logic signed [11:0] eq);
`ifdef QPSK_DIFF_EN
        logic [1:0] inc;
        case ({bi, bq})
            2'b00:   inc = 2'd0;
            2'b01:   inc = 2'd1;
            2'b11:   inc = 2'd2;
            default: inc = 2'd3;
        endcase
        p_out = p_in + inc;
        case (p_out)
            2'd0:    begin ei =  A; eq =  A; end
            2'd1:    begin ei = -A; eq =  A; end
            2'd2:    begin ei = -A; eq = -A; end
            default: begin ei =  A; eq = -A; end
        endcase
`else
        p_out = p_in;
        ei = bi ? -A : A;
        eq = bq ? -A : A;
`endif
    endtask

    task automatic compare(input string tag, input smp_t e, input logic ov,
                           input logic signed [11:0] oi, input logic signed [11:0] oq);
        check({tag, ".valid"}, {31'b0, ov}, {31'b0, e.v});
        check({tag, ".I"}, oi, e.i);
        check({tag, ".Q"}, oq, e.q);
    endtask

    // One cycle on the SPS=1 instance; called and returns at a falling edge.
    task automatic step1(input logic v, input logic bi, input logic bq,
                         input logic exp_rdy, input string tag);
        smp_t e;
        logic signed [11:0] ei, eq;
        logic [1:0] pn;
        d1_v = v; d1_i = bi; d1_q = bq;
        check({tag, ".ready"}, {31'b0, rdy1}, {31'b0, exp_rdy});
        @(posedge clk);
        if (v && exp_rdy) begin
            model(bi, bq, ph1, pn, ei, eq);
            ph1 = pn;
            sb1.push_back('{v: 1'b1, i: ei, q: eq});
        end
        @(negedge clk);
        if (sb1.size() > 0) e = sb1.pop_front();
        else e = '{v: 1'b0, i: 12'sd0, q: 12'sd0};
        compare(tag, e, ov1, oi1, oq1);
    endtask

    // One cycle on the SPS=4 instance; an accepted symbol queues four samples.
    task automatic step4(input logic v, input logic bi, input logic bq,
                         input logic exp_rdy, input string tag);
        smp_t e;
        logic signed [11:0] ei, eq;
        logic [1:0] pn;
        d4_v = v; d4_i = bi; d4_q = bq;
        check({tag, ".ready"}, {31'b0, rdy4}, {31'b0, exp_rdy});
        @(posedge clk);
        if (v && exp_rdy) begin
            model(bi, bq, ph4, pn, ei, eq);
            ph4 = pn;
            repeat (4) sb4.push_back('{v: 1'b1, i: ei, q: eq});
        end
        @(negedge clk);
        if (sb4.size() > 0) e = sb4.pop_front();
        else e = '{v: 1'b0, i: 12'sd0, q: 12'sd0};
        compare(tag, e, ov4, oi4, oq4);
    endtask

    initial begin
        logic [15:0] pat;
        smp_t zero;
        zero = '{v: 1'b0, i: 12'sd0, q: 12'sd0};
        rst_n = 1'b0;
        d1_v = 1'b0; d1_i = 1'b0; d1_q = 1'b0;
        d4_v = 1'b0; d4_i = 1'b0; d4_q = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        compare("rst1", zero, ov1, oi1, oq1);
        compare("rst4", zero, ov4, oi4, oq4);
        check("rst1.ready", {31'b0, rdy1}, 32'sd0);
        check("rst4.ready", {31'b0, rdy4}, 32'sd0);
        rst_n = 1'b1;
        #1;
        check("rel1.ready", {31'b0, rdy1}, 32'sd0);
        check("rel4.ready", {31'b0, rdy4}, 32'sd0);
        check("rel1.valid", {31'b0, ov1}, 32'sd0);
        @(posedge clk);
        @(negedge clk);
        check("rel2_1.ready", {31'b0, rdy1}, 32'sd1);
        check("rel2_4.ready", {31'b0, rdy4}, 32'sd1);

        // SPS=1 continuous stream, dibits (I,Q) taken LSB-first.
        pat = 16'b1110100101111000;
        for (int k = 0; k < 8; k++)
            step1(1'b1, pat[2*k], pat[2*k+1], 1'b1, $sformatf("stream%0d", k));

        // Two-cycle gap then resume.
        step1(1'b0, 1'b0, 1'b0, 1'b1, "gap0");
        step1(1'b0, 1'b0, 1'b0, 1'b1, "gap1");
        step1(1'b1, 1'b1, 1'b0, 1'b1, "resume0");
        step1(1'b1, 1'b0, 1'b1, 1'b1, "resume1");
        step1(1'b0, 1'b0, 1'b0, 1'b1, "drain1");

        // SPS=4 with i_valid held: 11 then 00 back-to-back.
        for (int k = 0; k < 4; k++)
            step4(1'b1, 1'b1, 1'b1, k == 0, $sformatf("hold11_%0d", k));
        for (int k = 0; k < 4; k++)
            step4(1'b1, 1'b0, 1'b0, k == 0, $sformatf("hold00_%0d", k));
        step4(1'b0, 1'b0, 1'b0, 1'b1, "end4");
        step4(1'b0, 1'b0, 1'b0, 1'b1, "idle4");

        // Mid-symbol reset at cnt = 1.
        step4(1'b1, 1'b0, 1'b1, 1'b1, "pre_rst0");
        step4(1'b0, 1'b0, 1'b0, 1'b0, "pre_rst1");
        rst_n = 1'b0;
        #1;
        compare("midrst4", zero, ov4, oi4, oq4);
        check("midrst4.ready", {31'b0, rdy4}, 32'sd0);
        sb4.delete();
        sb1.delete();
        ph1 = 2'd0;
        ph4 = 2'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step4(1'b1, 1'b0, 1'b1, 1'b0, "ignored");
        step4(1'b1, 1'b1, 1'b0, 1'b1, "post_rst0");
        for (int k = 1; k < 4; k++)
            step4(1'b0, 1'b0, 1'b0, 1'b0, $sformatf("post_rst%0d", k));
        step4(1'b0, 1'b0, 1'b0, 1'b1, "post_end");

        // Sequence 01, 01, 11, 00 on SPS=1 after reset.
        step1(1'b1, 1'b0, 1'b1, 1'b1, "seq0");
        step1(1'b1, 1'b0, 1'b1, 1'b1, "seq1");
        step1(1'b1, 1'b1, 1'b1, 1'b1, "seq2");
        step1(1'b1, 1'b0, 1'b0, 1'b1, "seq3");
        step1(1'b0, 1'b0, 1'b0, 1'b1, "seq_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
